mmio_uart_tx: RTL

Memory-mapped UART transmitter on the data side of `rv32i_multicycle_core`. It decodes the core's `mem_addr`/`mem_wr_data`/`mem_wr_ena` bus and returns `mem_rd_data` combinationally, so reads work under the core's same-cycle read timing. Stores queue bytes in a small FIFO, which a bit-serial 8N1 transmitter drains. `sel` tells the top-level read mux to take `mem_rd_data` from this block instead of RAM.

---
 rtl/mmio_defines.sv | 31 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_defines.sv
// mmio_defines
//   Shared constants for the memory-mapped UART transmitter:
//   register word offsets (mem_addr[3:2]), STATUS/CTRL bit positions
//   and the transmit FSM state type.
package mmio_defines;

   // Register word offsets, compared against mem_addr[3:2]
   localparam logic [1:0] MMIO_UART_TXDATA = 2'd0;  // 0x0
   localparam logic [1:0] MMIO_UART_STATUS = 2'd1;  // 0x4
   localparam logic [1:0] MMIO_UART_CTRL   = 2'd2;  // 0x8

   // STATUS bit positions
   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_BUSY    = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_W   = 5;

   // CTRL bit positions
   localparam int unsigned CTRL_TX_EN = 0;

   // Transmit FSM states, fixed legacy encoding
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with first-word fall-through read data.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, wr_data write strobe and data (ignored when full)
//     pop, rd_data  read strobe (ignored when empty), head-of-queue data
//     full, empty   occupancy flags
//     count         entries held, 0..DEPTH
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the core data bus.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     ena          global enable; low freezes FSM, baud counter, FIFO, writes
//     mem_addr     byte address from the core
//     mem_wr_data  store data
//     mem_wr_ena   store strobe (qualified by sel)
//     mem_rd_data  combinational read data, 0 when not selected
//     sel          address falls in the 16-byte register window
//     tx           serial line, idles high, driven from a flop
module mmio_uart_tx
   import mmio_defines::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_wr_ena,
   output logic [31:0] mem_rd_data,
   output logic        sel,
   output logic        tx
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]     reg_off;
   logic           wr_cycle;
   logic           push_req;
   logic           push;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  fifo_count;
   logic [7:0]     fifo_rd;

   uart_tx_state_t state;
   logic [15:0]    baud_cnt;
   logic           bit_done;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic           tx_q;
   logic           overflow;
   logic           tx_en;
   logic           start_ok;

   logic           unused_bits;

   assign sel      = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign reg_off  = mem_addr[3:2];
   assign wr_cycle = ena && sel && mem_wr_ena;
   assign push_req = wr_cycle && (reg_off == MMIO_UART_TXDATA);
   assign push     = push_req && !fifo_full;
   assign bit_done = (baud_cnt == 16'(CLKS_PER_BIT - 1));
   assign start_ok = tx_en && !fifo_empty;
   assign tx       = tx_q;

   assign unused_bits = ^{mem_wr_data[31:8], mem_addr[1:0]};

   // Pop coincides with the edge that loads the shift register: either
   // leaving IDLE or chaining straight from the end of a stop bit.
   always_comb begin
      pop = ena && start_ok &&
            ((state == S_IDLE) || ((state == S_STOP) && bit_done));
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (mem_wr_data[7:0]),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Overflow is judged on the pre-edge full flag, so a push that meets a
   // simultaneous pop on a full FIFO is still dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         tx_en    <= 1'b1;
      end else if (wr_cycle) begin
         if (push_req && fifo_full) overflow <= 1'b1;
         if ((reg_off == MMIO_UART_STATUS) && mem_wr_data[STAT_OVF]) overflow <= 1'b0;
         if (reg_off == MMIO_UART_CTRL) tx_en <= mem_wr_data[CTRL_TX_EN];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
      end else if (ena) begin
         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               if (start_ok) begin
                  state <= S_START;
                  shreg <= fifo_rd;
                  tx_q  <= 1'b0;
               end
            end
            S_START: begin
               if (bit_done) begin
                  state    <= S_DATA;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx_q     <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx_q    <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (start_ok) begin
                     state <= S_START;
                     shreg <= fifo_rd;
                     tx_q  <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                     tx_q  <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               baud_cnt <= '0;
               tx_q     <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      mem_rd_data = '0;
      if (sel) begin
         case (reg_off)
            MMIO_UART_STATUS: begin
               mem_rd_data[STAT_FULL]  = fifo_full;
               mem_rd_data[STAT_EMPTY] = fifo_empty;
               mem_rd_data[STAT_BUSY]  = (state != S_IDLE);
               mem_rd_data[STAT_OVF]   = overflow;
               mem_rd_data[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
            end
            MMIO_UART_CTRL: mem_rd_data[CTRL_TX_EN] = tx_en;
            default: ;
         endcase
      end
   end

endmodule
